// File: rtl/lfsr_pkg.sv
// Shared LFSR constants, FSM states and next-bit function for the
// 16-bit XNOR stream (taps 15,14,12,3) used by generator and checker.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 16;
  localparam int TAP0 = 15;
  localparam int TAP1 = 14;
  localparam int TAP2 = 12;
  localparam int TAP3 = 3;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic lfsr_next_bit(
    input logic [LFSR_WIDTH-1:0] r
  );
    return ~(r[TAP0] ^ r[TAP1] ^ r[TAP2] ^ r[TAP3]);
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream.
// Optional LFSR_CHECKER_RESYNC_EN: 16 straight misses drop lock.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int WINDOW   = 64,
  parameter int ERR_MAX  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [1:0]  state_o
);

  localparam int WW = $clog2(WINDOW + 1);
  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [WW-1:0] ERR_C = WW'(ERR_MAX);

  state_e                  state;
  logic [LFSR_WIDTH-1:0]   r;
  logic [3:0]              fill;
  logic [7:0]              match;
  logic [WW-1:0]           wcnt;
  logic [WW-1:0]           werr;

  logic                    p;
  logic                    mis;
  logic [LFSR_WIDTH-1:0]   r_in;
  logic [WW-1:0]           werr_nx;
  logic                    run_hit;
  logic                    lose;

  assign p       = lfsr_next_bit(r);
  assign mis     = bit_in != p;
  assign r_in    = {r[14:0], bit_in};
  assign werr_nx = werr + {{(WW-1){1'b0}}, mis};
  assign state_o = state;

`ifdef LFSR_CHECKER_RESYNC_EN
  logic [4:0] run;
  assign run_hit = mis && (run == 5'd15);
`else
  assign run_hit = 1'b0;
`endif

  // the bit that fills the window still counts toward loss of lock
  assign lose = mis && ((werr_nx == ERR_C) || run_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      r         <= '0;
      fill      <= '0;
      match     <= '0;
      wcnt      <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef LFSR_CHECKER_RESYNC_EN
      run       <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
      case (state)
        SEARCH: begin
          if (bit_valid) begin
            r    <= r_in;
            fill <= fill + 4'd1;
            if (fill == 4'd15) begin
              state <= VERIFY;
              match <= '0;
            end
          end
        end
        VERIFY: begin
          if (bit_valid) begin
            r <= r_in;
            if (mis) begin
              state <= SEARCH;
              fill  <= '0;
            end else if (match + 8'd1 == LOCK_C) begin
              match <= '0;
              // all-ones is the XNOR lock-up state, never a real lock
              if (r_in == 16'hFFFF) begin
                state <= SEARCH;
                fill  <= '0;
              end else begin
                state  <= LOCKED;
                locked <= 1'b1;
                wcnt   <= '0;
                werr   <= '0;
`ifdef LFSR_CHECKER_RESYNC_EN
                run    <= '0;
`endif
              end
            end else begin
              match <= match + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (bit_valid) begin
            // flywheel on prediction so a flipped bit is counted once
            r <= {r[14:0], p};
            if (mis) begin
              err_pulse <= 1'b1;
              if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            end
`ifdef LFSR_CHECKER_RESYNC_EN
            run <= mis ? run + 5'd1 : 5'd0;
`endif
            if (lose) begin
              state  <= SEARCH;
              locked <= 1'b0;
              fill   <= '0;
            end else if (wcnt == WIN_LAST) begin
              wcnt <= '0;
              werr <= '0;
            end else begin
              wcnt <= wcnt + {{(WW-1){1'b0}}, 1'b1};
              werr <= werr_nx;
            end
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
          fill   <= '0;
        end
      endcase
    end
  end

endmodule
